mp3_key_conditioner: RTL and testbench

Debounces and conditions the two raw, active-low player push-buttons and produces the clean active-high levels that drive the SoC `keys_export[1:0]` PIO input. It also emits per-key single-cycle press, release and auto-repeat strobes for hardware consumers such as the volume ramp logic. It sits between the board key pins and `mp3player_soc`, in the `clk_clk` domain.

---
 rtl/mp3_key_conditioner.sv | 179 +++++++++++++++++
 tb/tb_mp3_key_conditioner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mp3_key_conditioner.sv
// Purpose : debounce the active-low player keys into clean active-high levels plus press/release/repeat strobes.
// Latency : level and press/release strobe change DEBOUNCE_CYCLES+2 edges after the first edge that samples a stable pin change.
// Backpr. : none; strobes are single-cycle and are not queued.
//
// Ports:
//   clk_clk        system clock (SoC clk_clk net)
//   reset_reset_n  asynchronous active-low reset
//   key_n          raw asynchronous key pins, 0 = pressed
//   keys_out       debounced level, 1 = pressed (drives keys_export)
//   press_pulse    one-cycle strobe on an accepted press
//   release_pulse  one-cycle strobe on an accepted release
//   repeat_pulse   one-cycle strobe after the hold time and every repeat interval after that

module mp3_key_conditioner #(
    parameter int unsigned NUM_KEYS        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] keys_out,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse
);

    // Counter only ever has to reach (largest interval - 1).
    localparam int unsigned MAX_A  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_C  = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
    localparam int unsigned CW     = (MAX_C > 2) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMING    = 3'd1,
        ST_DOWN      = 3'd2,
        ST_REPEAT    = 3'd3,
        ST_DISARMING = 3'd4
    } state_t;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key

        logic          sync_1;
        logic          sync_2;
        logic          s;
        state_t        state_q;
        state_t        state_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          level_q;
        logic          level_d;
        logic          press_q;
        logic          press_d;
        logic          release_q;
        logic          release_d;
        logic          repeat_q;
        logic          repeat_d;

        // Two-flop synchronizer; reset value 1 means "released" so a key
        // held through reset is seen as a fresh press afterwards.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                sync_1 <= 1'b1;
                sync_2 <= 1'b1;
            end else begin
                sync_1 <= key_n[i];
                sync_2 <= sync_1;
            end
        end

        assign s = ~sync_2;

        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                repeat_q  <= repeat_d;
            end
        end

        // Next state, counter and next registered outputs. Any transition
        // (including the REPEAT self-loop on a repeat strobe) clears the
        // counter; otherwise it counts in every state except IDLE.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            repeat_d  = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (s) begin
                        state_d = ST_ARMING;
                    end
                end
                ST_ARMING: begin
                    if (!s) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = ST_DOWN;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DOWN: begin
                    if (!s) begin
                        state_d = ST_DISARMING;
                        cnt_d   = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d  = ST_REPEAT;
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!s) begin
                        state_d = ST_DISARMING;
                        cnt_d   = '0;
                    end else if (cnt_q == REP_LAST) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DISARMING: begin
                    // A release glitch returns to DOWN, which restarts the
                    // hold timer rather than resuming the repeat cadence.
                    if (s) begin
                        state_d = ST_DOWN;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            level_d = (state_d == ST_DOWN) || (state_d == ST_REPEAT) ||
                      (state_d == ST_DISARMING);
        end

        assign keys_out[i]      = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign repeat_pulse[i]  = repeat_q;

    end : g_key

endmodule

// File: tb/tb_mp3_key_conditioner.sv
// Purpose : self-checking bench for mp3_key_conditioner with short timing parameters.
// Latency : checks every cycle against an event-level model of the key behaviour.
// Backpr. : n/a.

module tb_mp3_key_conditioner;

    localparam int D = 8;
    localparam int H = 32;
    localparam int R = 12;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic [1:0] key_n;
    logic [1:0] keys_out;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] repeat_pulse;

    int total = 0;
    int bad   = 0;

    always #5 clk_clk = ~clk_clk;

    mp3_key_conditioner #(
        .NUM_KEYS        (2),
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .key_n         (key_n),
        .keys_out      (keys_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    // Reference model: per key, the pressed level seen by the conditioner
    // lags the pin by two edges. A press is accepted once that level has
    // been 1 for D+1 consecutive edges while released, a release once it
    // has been 0 for D+1 edges while pressed. Repeats are scheduled from an
    // anchor edge (the press, or the end of a rejected release glitch):
    // anchor+H, then every R edges.
    int         cyc;
    bit         m_h1    [2];
    bit         m_h2    [2];
    bit         m_prev  [2];
    bit         m_level [2];
    int         m_run   [2];
    int         m_anchor[2];
    logic [1:0] m_keys, m_press, m_rel, m_rep;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_h1[k]     = 1'b0;
            m_h2[k]     = 1'b0;
            m_prev[k]   = 1'b0;
            m_level[k]  = 1'b0;
            m_run[k]    = 0;
            m_anchor[k] = 0;
        end
        m_keys  = 2'b00;
        m_press = 2'b00;
        m_rel   = 2'b00;
        m_rep   = 2'b00;
    endtask

    task automatic model_edge();
        bit s;
        int age;
        cyc++;
        if (!reset_reset_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                s       = m_h2[k];
                m_h2[k] = m_h1[k];
                m_h1[k] = ~key_n[k];
                if (s == m_prev[k]) m_run[k]++;
                else                m_run[k] = 1;
                m_prev[k]  = s;
                m_press[k] = 1'b0;
                m_rel[k]   = 1'b0;
                m_rep[k]   = 1'b0;
                if (!m_level[k]) begin
                    if (s && m_run[k] == D + 1) begin
                        m_level[k]  = 1'b1;
                        m_press[k]  = 1'b1;
                        m_anchor[k] = cyc;
                    end
                end else if (!s) begin
                    if (m_run[k] == D + 1) begin
                        m_level[k] = 1'b0;
                        m_rel[k]   = 1'b1;
                    end
                end else if (m_run[k] == 1) begin
                    m_anchor[k] = cyc;
                end else begin
                    age = cyc - m_anchor[k];
                    if (age == H || (age > H && (age - H) % R == 0)) m_rep[k] = 1'b1;
                end
                m_keys[k] = m_level[k];
            end
        end
    endtask

    // One clock: DUT updates on the rising edge, model and comparison on
    // the following falling edge; inputs are changed by the caller after.
    task automatic step();
        @(posedge clk_clk);
        @(negedge clk_clk);
        model_edge();
        check("cycle_outputs", {keys_out, press_pulse, release_pulse, repeat_pulse},
              {m_keys, m_press, m_rel, m_rep});
    endtask

    initial begin
        cyc           = 0;
        key_n         = 2'b11;
        reset_reset_n = 1'b0;
        model_reset();

        // Reset values
        #1;
        check("reset_outputs", {keys_out, press_pulse, release_pulse, repeat_pulse}, 8'h00);
        repeat (3) step();
        reset_reset_n = 1'b1;
        repeat (50) step();
        check("post_reset_idle", {keys_out, press_pulse, release_pulse, repeat_pulse}, 8'h00);

        // Clean press on key 0: edge 0 is the first step
        key_n[0] = 1'b0;
        repeat (10) step();
        check("press0_before_edge10", 8'(press_pulse[0]), 8'h00);
        step();
        check("press0_at_edge10", 8'(press_pulse[0]), 8'h01);
        check("keys0_at_edge10", 8'(keys_out[0]), 8'h01);
        check("key1_untouched", {6'b0, keys_out[1], press_pulse[1]}, 8'h00);

        // Hold and repeat
        for (int j = 1; j <= 100; j++) begin
            step();
            check("repeat0_offset", 8'(repeat_pulse[0]),
                  8'((j >= H && (j - H) % R == 0) ? 1 : 0));
        end
        key_n[0] = 1'b1;
        repeat (10) step();
        check("release0_before_edge10", 8'(release_pulse[0]), 8'h00);
        step();
        check("release0_at_edge10", 8'(release_pulse[0]), 8'h01);
        check("keys0_after_release", 8'(keys_out[0]), 8'h00);

        // Bounce rejection on key 1
        key_n[1] = 1'b0; repeat (7) step();
        key_n[1] = 1'b1; repeat (3) step();
        key_n[1] = 1'b0; repeat (7) step();
        key_n[1] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            check("bounce1_quiet", {keys_out[1], press_pulse[1], release_pulse[1], repeat_pulse[1]}, 8'h00);
        end
        key_n[1] = 1'b0;
        repeat (10) step();
        check("bounce1_no_early_press", 8'(press_pulse[1]), 8'h00);
        step();
        check("press1_after_bounce", 8'(press_pulse[1]), 8'h01);
        key_n[1] = 1'b1;
        repeat (12) step();
        check("keys1_released", 8'(keys_out[1]), 8'h00);

        // Release glitch while DOWN restarts the hold timer
        key_n[0] = 1'b0;
        repeat (11) step();
        check("press0_again", 8'(press_pulse[0]), 8'h01);
        repeat (5) step();
        key_n[0] = 1'b1; repeat (5) step();
        key_n[0] = 1'b0;
        for (int j = 1; j <= 35; j++) begin
            step();
            check("glitch_level_held", {keys_out[0], release_pulse[0]}, 8'h02);
            check("glitch_repeat_timing", 8'(repeat_pulse[0]), 8'((j == 35) ? 1 : 0));
        end
        key_n[0] = 1'b1;
        repeat (12) step();

        // Simultaneous press, then reset mid-press
        key_n = 2'b00;
        repeat (10) step();
        step();
        check("press_both", 8'(press_pulse), 8'h03);
        repeat (3) step();
        reset_reset_n = 1'b0;
        #1;
        model_reset();
        check("reset_mid_press", {keys_out, press_pulse, release_pulse, repeat_pulse}, 8'h00);
        repeat (2) step();
        reset_reset_n = 1'b1;
        repeat (10) step();
        check("no_press_before_edge10", 8'(press_pulse), 8'h00);
        step();
        check("press_both_after_reset", 8'(press_pulse), 8'h03);

        // Randomized key activity on both channels against the model
        key_n = 2'b11;
        repeat (12) step();
        for (int seg = 0; seg < 120; seg++) begin
            key_n = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 60)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
